li_arbiter: RTL and testbench

//  Lateral-inhibition responder for the N output neurons: answers each neuron's start_li

---
 rtl/li_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_li_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/li_arbiter.sv
// Lateral-inhibition arbiter: collects per-neuron requests, scans the latched
// potentials for the highest value at or above threshold, and answers every
// requester in a single response cycle.

// Per-neuron potential latch, loaded when that neuron's request is accepted.
module li_pot_lane #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld_i,
    input  logic [W-1:0] pot_i,
    output logic [W-1:0] pot_o
);
    logic [W-1:0] pot_q;

    // Capture the bus value only on an accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    pot_q <= '0;
        else if (ld_i) pot_q <= pot_i;
    end

    assign pot_o = pot_q;
endmodule

module li_arbiter #(
    parameter int N      = 8,
    parameter int W      = 24,
    parameter int TH     = 15018,
    parameter int IDX_W  = 3,
    parameter int COL_TO = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_core_img_i,
    input  logic [N-1:0]     start_li_i,
    input  logic [N*W-1:0]   potential_bus_i,
    output logic             li_o,
    output logic [N-1:0]     valid_li_o,
    output logic [N-1:0]     won_lost_o,
    output logic [IDX_W-1:0] winner_idx_o,
    output logic             proto_err_o
);
    localparam int TMR_W = $clog2(COL_TO) + 1;
    localparam logic signed [W-1:0] TH_S = W'(TH);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_SCAN, S_RESP} state_t;

    state_t              state_q, state_d;
    logic [N-1:0]        pending_q, pending_d;
    logic [N-1:0]        ld;
    logic [N-1:0][W-1:0] pot_q;
    logic [IDX_W-1:0]    cnt_q, cnt_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic signed [W-1:0] best_val_q, best_val_d;
    logic [IDX_W-1:0]    best_idx_q, best_idx_d;
    logic                found_q, found_d;
    logic                li_q, li_d;
    logic [N-1:0]        valid_q, valid_d;
    logic [N-1:0]        won_q, won_d;
    logic [IDX_W-1:0]    widx_q, widx_d;
    logic                perr_q, perr_d;
    logic [N-1:0]        new_req, rep_req;
    logic signed [W-1:0] cur_pot;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            li_pot_lane #(.W(W)) u_lane (
                .clk   (clk),
                .rst_n (rst_n),
                .ld_i  (ld[gi]),
                .pot_i (potential_bus_i[W*gi +: W]),
                .pot_o (pot_q[gi])
            );
        end
    endgenerate

    assign cur_pot = pot_q[cnt_q];

    // Next-state and registered-output logic; image restart overrides everything.
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        ld         = '0;
        cnt_d      = cnt_q;
        timer_d    = timer_q;
        best_val_d = best_val_q;
        best_idx_d = best_idx_q;
        found_d    = found_q;
        li_d       = li_q;
        valid_d    = '0;
        won_d      = '0;
        widx_d     = widx_q;
        perr_d     = 1'b0;
        new_req    = start_li_i & ~pending_q;
        rep_req    = start_li_i & pending_q;
        if (start_core_img_i) begin
            state_d   = S_IDLE;
            pending_d = '0;
            li_d      = 1'b0;
            found_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (|start_li_i) begin
                        pending_d = pending_q | start_li_i;
                        ld        = start_li_i;
                        timer_d   = '0;
                        state_d   = S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    // Repeat requests are flagged and dropped; fresh ones are latched.
                    perr_d    = |rep_req;
                    ld        = new_req;
                    pending_d = pending_q | new_req;
                    timer_d   = timer_q + 1'b1;
                    if ((&pending_q) || (timer_q == TMR_W'(COL_TO - 1))) begin
                        state_d    = S_SCAN;
                        cnt_d      = '0;
                        found_d    = 1'b0;
                        best_val_d = '0;
                        best_idx_d = '0;
                    end
                end
                S_SCAN: begin
                    perr_d = |start_li_i;
                    // Strictly-greater replacement keeps the lowest index on ties.
                    if (pending_q[cnt_q] && (cur_pot >= TH_S) &&
                        (!found_q || (cur_pot > best_val_q))) begin
                        found_d    = 1'b1;
                        best_val_d = cur_pot;
                        best_idx_d = cnt_q;
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == IDX_W'(N - 1)) begin
                        // Response registers load here so they are visible during RESP.
                        state_d = S_RESP;
                        valid_d = pending_q;
                        if (found_d) begin
                            won_d[best_idx_d] = 1'b1;
                            widx_d            = best_idx_d;
                            li_d              = 1'b1;
                        end else begin
                            won_d = pending_q;
                        end
                    end
                end
                S_RESP: begin
                    perr_d    = |start_li_i;
                    pending_d = '0;
                    state_d   = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pending_q  <= '0;
            cnt_q      <= '0;
            timer_q    <= '0;
            best_val_q <= '0;
            best_idx_q <= '0;
            found_q    <= 1'b0;
            li_q       <= 1'b0;
            valid_q    <= '0;
            won_q      <= '0;
            widx_q     <= '0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            cnt_q      <= cnt_d;
            timer_q    <= timer_d;
            best_val_q <= best_val_d;
            best_idx_q <= best_idx_d;
            found_q    <= found_d;
            li_q       <= li_d;
            valid_q    <= valid_d;
            won_q      <= won_d;
            widx_q     <= widx_d;
            perr_q     <= perr_d;
        end
    end

    assign li_o         = li_q;
    assign valid_li_o   = valid_q;
    assign won_lost_o   = won_q;
    assign winner_idx_o = widx_q;
    assign proto_err_o  = perr_q;
endmodule

// File: tb/tb_li_arbiter.sv
// Randomized and directed bench for li_arbiter against a timeline/max-search model.
module tb_li_arbiter;
    localparam int N = 8, W = 24, TH = 15018, IDX_W = 3, COL_TO = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start_core_img = 1'b0;
    logic [N-1:0]     start_li = '0;
    logic [N*W-1:0]   bus = '0;
    logic             li;
    logic [N-1:0]     valid_li, won_lost;
    logic [IDX_W-1:0] winner_idx;
    logic             proto_err;

    int total = 0, bad = 0;
    int pv[N];
    logic m_li = 1'b0;
    int m_widx = 0;

    li_arbiter #(.N(N), .W(W), .TH(TH), .IDX_W(IDX_W), .COL_TO(COL_TO)) dut (
        .clk(clk), .rst_n(rst_n), .start_core_img_i(start_core_img),
        .start_li_i(start_li), .potential_bus_i(bus), .li_o(li),
        .valid_li_o(valid_li), .won_lost_o(won_lost), .winner_idx_o(winner_idx),
        .proto_err_o(proto_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bus(input int alt_n, input int alt_v);
        logic [W-1:0] t;
        for (int i = 0; i < N; i++) begin
            t = (i == alt_n) ? alt_v[W-1:0] : pv[i][W-1:0];
            bus[W*i +: W] = t;
        end
    endtask

    task automatic set_all(input int v);
        for (int i = 0; i < N; i++) pv[i] = v;
    endtask

    // One arbitration round; model derives timing and verdict from the rules directly.
    task automatic run_txn(input string nm, input logic [N-1:0] req0, input logic [N-1:0] late,
                           input int k, input logic [N-1:0] rereq, input int rk, input int alt_v);
        logic [N-1:0] pend, ew, got_v, got_w, drv;
        int e, vcyc, maxv, idx, first_v, nv, alt_n;
        bit found, perr_bad, pe;
        int perr_exp[$];
        pend = req0 | ((late != 0 && k <= COL_TO) ? late : '0);
        if (req0 == '1) e = 1;
        else if (late != 0 && k <= COL_TO && pend == '1) e = (k + 1 < COL_TO) ? k + 1 : COL_TO;
        else e = COL_TO;
        vcyc = e + 1 + N;
        found = 0; maxv = 0; idx = 0;
        for (int i = 0; i < N; i++)
            if (pend[i] && pv[i] >= TH) begin
                if (!found || pv[i] > maxv) maxv = pv[i];
                found = 1;
            end
        for (int i = N - 1; i >= 0; i--)
            if (found && pend[i] && pv[i] >= TH && pv[i] == maxv) idx = i;
        if (found) begin
            ew = '0; ew[idx] = 1'b1; m_li = 1'b1; m_widx = idx;
        end else ew = pend;
        if (late != 0 && k > COL_TO) perr_exp.push_back(k + 1);
        if (rereq != 0) perr_exp.push_back(rk + 1);
        alt_n = -1;
        for (int i = 0; i < N; i++) if (rereq[i]) alt_n = i;

        set_bus(-1, 0);
        start_li = req0;
        tick();
        start_li = '0;
        first_v = -1; nv = 0; perr_bad = 0; got_v = '0; got_w = '0;
        for (int c = 1; c <= vcyc + 3; c++) begin
            if (valid_li != 0) begin
                nv++;
                if (first_v < 0) begin first_v = c; got_v = valid_li; got_w = won_lost; end
            end
            pe = 0;
            foreach (perr_exp[j]) if (perr_exp[j] == c) pe = 1;
            if (proto_err !== pe) perr_bad = 1;
            drv = '0;
            if (c == k) drv = drv | late;
            if (c == rk) drv = drv | rereq;
            start_li = drv;
            set_bus((c == rk) ? alt_n : -1, alt_v);
            tick();
            start_li = '0;
            set_bus(-1, 0);
        end
        total++; if (first_v != vcyc) begin bad++; $display("FAIL %s latency got=%0d exp=%0d", nm, first_v, vcyc); end
        total++; if (nv != 1) begin bad++; $display("FAIL %s valid_cycles got=%0d exp=1", nm, nv); end
        total++; if (got_v !== pend) begin bad++; $display("FAIL %s valid_li got=%h exp=%h", nm, got_v, pend); end
        total++; if (got_w !== ew) begin bad++; $display("FAIL %s won_lost got=%h exp=%h", nm, got_w, ew); end
        total++; if (winner_idx !== IDX_W'(m_widx)) begin bad++; $display("FAIL %s winner_idx got=%0d exp=%0d", nm, winner_idx, m_widx); end
        total++; if (li !== m_li) begin bad++; $display("FAIL %s li got=%b exp=%b", nm, li, m_li); end
        total++; if (perr_bad) begin bad++; $display("FAIL %s proto_err pattern got=wrong exp=%0d pulses", nm, perr_exp.size()); end
    endtask

    task automatic clear_img();
        start_core_img = 1'b1;
        tick();
        start_core_img = 1'b0;
        m_li = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if ({li, valid_li, won_lost, winner_idx, proto_err} !== '0) begin
            bad++; $display("FAIL reset outputs got=%h exp=0", {li, valid_li, won_lost, winner_idx, proto_err});
        end
    endtask

    task automatic test_all_same();
        set_all(0); pv[0] = 1000; pv[1] = 20000; pv[2] = 16000;
        run_txn("all_same", 8'hFF, 8'h00, 0, 8'h00, 0, 0);
    endtask

    task automatic test_tie();
        set_all(100); pv[3] = 18000; pv[6] = 18000;
        run_txn("tie", 8'hFF, 8'h00, 0, 8'h00, 0, 0);
    endtask

    task automatic test_no_cand();
        clear_img();
        set_all(15017);
        run_txn("no_cand", 8'hFF, 8'h00, 0, 8'h00, 0, 0);
    endtask

    task automatic test_partial();
        set_all(0); pv[0] = 15018; pv[2] = -5;
        run_txn("partial", 8'h05, 8'h00, 0, 8'h00, 0, 0);
    endtask

    task automatic test_proto();
        set_all(0); pv[1] = 16000; pv[4] = 100;
        run_txn("rereq_scan", 8'hFF, 8'h00, 0, 8'h10, 4, 30000);
        set_all(0); pv[0] = 16000; pv[1] = 17000;
        run_txn("rereq_collect", 8'h01, 8'h0E, 3, 8'h01, 3, 30000);
    endtask

    task automatic test_random();
        int tbl[9] = '{TH - 1, TH, TH + 1, 18000, 18000, -5, 0, 20000, TH};
        logic [N-1:0] r0, lt;
        for (int it = 0; it < 14; it++) begin
            for (int i = 0; i < N; i++) pv[i] = tbl[$urandom_range(0, 8)];
            r0 = N'($urandom_range(1, 254));
            lt = N'($urandom) & ~r0;
            if (it % 3 == 0) lt = ~r0;
            run_txn("random", r0, lt, $urandom_range(1, 20), 8'h00, 0, 0);
        end
    endtask

    task automatic test_abort();
        bit seen;
        set_all(0); pv[5] = 19000;
        run_txn("pre_abort", 8'hFF, 8'h00, 0, 8'h00, 0, 0);
        set_bus(-1, 0);
        start_li = 8'hFF;
        tick();
        start_li = '0;
        for (int c = 1; c < 5; c++) tick();
        start_core_img = 1'b1; start_li = 8'h01;
        tick();
        start_core_img = 1'b0; start_li = '0;
        m_li = 1'b0;
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            if (valid_li != 0) seen = 1;
            tick();
        end
        total++; if (seen) begin bad++; $display("FAIL abort valid_li got=seen exp=none"); end
        total++; if (li !== 1'b0) begin bad++; $display("FAIL abort li got=%b exp=0", li); end
        set_all(0); pv[2] = 16500;
        run_txn("post_abort", 8'hFF, 8'h00, 0, 8'h00, 0, 0);
    endtask

    task automatic test_async_reset();
        bit seen;
        set_all(0); pv[6] = 21000;
        run_txn("pre_reset", 8'hFF, 8'h00, 0, 8'h00, 0, 0);
        start_li = 8'h03;
        tick();
        start_li = '0;
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        m_li = 1'b0; m_widx = 0;
        total++;
        if ({li, valid_li, won_lost, winner_idx, proto_err} !== '0) begin
            bad++; $display("FAIL async_reset outputs got=%h exp=0", {li, valid_li, won_lost, winner_idx, proto_err});
        end
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            if (valid_li != 0) seen = 1;
            tick();
        end
        total++; if (seen) begin bad++; $display("FAIL async_reset stale_resp got=seen exp=none"); end
        set_all(0); pv[7] = 15018;
        run_txn("post_reset", 8'hC0, 8'h00, 0, 8'h00, 0, 0);
    endtask

    initial begin
        set_all(0);
        set_bus(-1, 0);
        tick(); tick();
        test_reset();
        rst_n = 1'b1;
        tick();
        test_reset();
        test_all_same();
        test_tie();
        test_no_cand();
        test_partial();
        test_proto();
        test_random();
        test_abort();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
